// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the cache read arbiter: FSM states, read-type codes
// and the beat count of a cache-line refill.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam int LINE_BEATS = 4;

    // Only line refills are bursts; every other type returns a single beat.
    function automatic logic [2:0] expected_beats(input logic [2:0] rd_type);
        return (rd_type == RD_TYPE_LINE) ? 3'(LINE_BEATS) : 3'd1;
    endfunction

endpackage

// File: rtl/rd_beat_counter.sv
// 3-bit beat counter: loads the expected burst length, counts returned beats
// down and flags when the final beat is due.
module rd_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       is_one_o
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one_o = (count_q == 3'd1);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates iCache and dCache refill reads onto one AXI read port with a
// single outstanding transaction. Define ARB_ROUND_ROBIN_EN for round-robin
// grants; otherwise the dCache always wins a tie.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_rd_req,
    input  logic [2:0]        inst_rd_type,
    input  logic [ADDR_W-1:0] inst_rd_addr,
    output logic              inst_rd_rdy,
    output logic              inst_ret_valid,
    output logic              inst_ret_last,
    output logic [DATA_W-1:0] inst_ret_data,
    input  logic              data_rd_req,
    input  logic [2:0]        data_rd_type,
    input  logic [ADDR_W-1:0] data_rd_addr,
    output logic              data_rd_rdy,
    output logic              data_ret_valid,
    output logic              data_ret_last,
    output logic [DATA_W-1:0] data_ret_data,
    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [DATA_W-1:0] ret_data,
    output logic              busy,
    output logic              owner,
    output logic              proto_err
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [2:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              proto_err_q, proto_err_d;
    logic              win_data;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_is_one;
`ifdef ARB_ROUND_ROBIN_EN
    logic              favour_data_q, favour_data_d;
`endif

    rd_beat_counter u_beat_counter (
        .clk       (clk),
        .rst       (reset),
        .load_i    (cnt_load),
        .load_val_i(expected_beats(type_q)),
        .dec_i     (cnt_dec),
        .is_one_o  (cnt_is_one)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        type_d      = type_q;
        addr_d      = addr_q;
        proto_err_d = proto_err_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        favour_data_d = favour_data_q;
        win_data      = data_rd_req && (!inst_rd_req || favour_data_q);
`else
        win_data      = data_rd_req;
`endif

        case (state_q)
            IDLE: begin
                if (ret_valid) begin
                    proto_err_d = 1'b1;
                end
                if (inst_rd_req || data_rd_req) begin
                    owner_d = win_data;
                    type_d  = win_data ? data_rd_type : inst_rd_type;
                    addr_d  = win_data ? data_rd_addr : inst_rd_addr;
                    state_d = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    favour_data_d = !win_data;
`endif
                end
            end
            ISSUE: begin
                if (ret_valid) begin
                    proto_err_d = 1'b1;
                end
                if (rd_rdy) begin
                    cnt_load = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (ret_valid) begin
                    cnt_dec = 1'b1;
                    // A last flag off the expected beat, or running out of beats
                    // without one, both end the burst and are recorded.
                    if (ret_last) begin
                        state_d = IDLE;
                        if (!cnt_is_one) begin
                            proto_err_d = 1'b1;
                        end
                    end else if (cnt_is_one) begin
                        state_d     = IDLE;
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            type_q      <= 3'd0;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            favour_data_q <= 1'b1;
        end else begin
            favour_data_q <= favour_data_d;
        end
    end
`endif

    assign rd_req  = (state_q == ISSUE);
    assign rd_type = rd_req ? type_q : 3'd0;
    assign rd_addr = rd_req ? addr_q : '0;

    assign inst_rd_rdy = rd_req && !owner_q && rd_rdy;
    assign data_rd_rdy = rd_req &&  owner_q && rd_rdy;

    assign inst_ret_valid = (state_q == RESP) && !owner_q && ret_valid;
    assign inst_ret_last  = (state_q == RESP) && !owner_q && ret_last;
    assign data_ret_valid = (state_q == RESP) &&  owner_q && ret_valid;
    assign data_ret_last  = (state_q == RESP) &&  owner_q && ret_last;
    assign inst_ret_data  = ret_data;
    assign data_ret_data  = ret_data;

    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter; tie-break expectations follow
// ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_rd_req, data_rd_req;
    logic [2:0]  inst_rd_type, data_rd_type;
    logic [31:0] inst_rd_addr, data_rd_addr;
    logic        inst_rd_rdy, data_rd_rdy;
    logic        inst_ret_valid, inst_ret_last, data_ret_valid, data_ret_last;
    logic [31:0] inst_ret_data, data_ret_data;
    logic        rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr, ret_data;
    logic        busy, owner, proto_err;
    logic        exp_owner2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
        .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid),
        .inst_ret_last(inst_ret_last), .inst_ret_data(inst_ret_data),
        .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
        .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid),
        .data_ret_last(data_ret_last), .data_ret_data(data_ret_data),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .busy(busy), .owner(owner), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {rd_req, rd_type, rd_addr, inst_rd_rdy, data_rd_rdy,
                  inst_ret_valid, inst_ret_last, data_ret_valid, data_ret_last,
                  busy, owner, proto_err}, 64'd0);
    endtask

    // From ISSUE: accept the request, then return one beat flagged last.
    task automatic serve_word(input logic exp_own, input string tag);
        rd_rdy = 1'b1;
        #1;
        chk({tag, "_rdy"}, {inst_rd_rdy, data_rd_rdy}, exp_own ? 64'h1 : 64'h2);
        tick();
        rd_rdy    = 1'b0;
        ret_valid = 1'b1;
        ret_last  = 1'b1;
        ret_data  = 32'h5A5A_0000 + 32'(checks);
        #1;
        chk({tag, "_retv"}, {inst_ret_valid, data_ret_valid}, exp_own ? 64'h1 : 64'h2);
        chk({tag, "_data"}, exp_own ? data_ret_data : inst_ret_data, ret_data);
        tick();
        ret_valid = 1'b0;
        ret_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        inst_rd_req = 0; inst_rd_type = 0; inst_rd_addr = 0;
        data_rd_req = 0; data_rd_type = 0; data_rd_addr = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        reset = 1'b0;
        tick();
        chk_all_zero("post_reset_idle");

        // inst-only LINE refill, rd_rdy delayed two cycles, four beats
        inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1FC0_0000;
        tick();
        chk("line_rd_req", rd_req, 1);
        chk("line_rd_addr", rd_addr, 32'h1FC0_0000);
        chk("line_rd_type", rd_type, 3'b100);
        chk("line_owner", owner, 0);
        chk("line_busy", busy, 1);
        inst_rd_req = 0;
        tick(); tick();
        chk("line_req_held", rd_req, 1);
        chk("line_rdy_wait", inst_rd_rdy, 0);
        rd_rdy = 1;
        #1;
        chk("line_rdy_route", {inst_rd_rdy, data_rd_rdy}, 64'h2);
        tick();
        rd_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1; ret_last = (i == 3); ret_data = 32'h11 * (i + 1);
            #1;
            chk($sformatf("line_beat%0d_valid", i), {inst_ret_valid, data_ret_valid}, 64'h2);
            chk($sformatf("line_beat%0d_data", i), inst_ret_data, 32'h11 * (i + 1));
            chk($sformatf("line_beat%0d_last", i), inst_ret_last, (i == 3) ? 64'd1 : 64'd0);
            tick();
        end
        ret_valid = 0; ret_last = 0;
        chk("line_done_busy", busy, 0);
        chk("line_done_err", proto_err, 0);

        // simultaneous requests, twice, then data drops out
        inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h0000_0100;
        data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_0200;
        tick();
        chk("tie1_owner", owner, 1);
        chk("tie1_addr", rd_addr, 32'h0000_0200);
        serve_word(1, "tie1");
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        exp_owner2 = 1'b0;
`else
        exp_owner2 = 1'b1;
`endif
        chk("tie2_owner", owner, exp_owner2);
        chk("tie2_addr", rd_addr, exp_owner2 ? 32'h0000_0200 : 32'h0000_0100);
        serve_word(exp_owner2, "tie2");
        data_rd_req = 0;
        tick();
        chk("inst_after_data_owner", owner, 0);
        chk("inst_after_data_addr", rd_addr, 32'h0000_0100);
        inst_rd_req = 0;
        serve_word(0, "inst_after_data");

        // data WORD read, then a re-request during the last beat
        data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'hBFAF_8000;
        tick();
        chk("word_addr", rd_addr, 32'hBFAF_8000);
        chk("word_type", rd_type, 3'b010);
        chk("word_owner", owner, 1);
        data_rd_req = 0;
        rd_rdy = 1;
        tick();
        rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'hCAFE_F00D;
        data_rd_req = 1;
        #1;
        chk("word_last", {inst_ret_last, data_ret_last}, 64'h1);
        chk("word_data", data_ret_data, 32'hCAFE_F00D);
        tick();
        ret_valid = 0; ret_last = 0;
        chk("word_dead_cycle", rd_req, 0);
        tick();
        chk("word_regrant", rd_req, 1);
        data_rd_req = 0;
        serve_word(1, "word_regrant");

        // LINE with last on beat 2
        inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1FC0_0040;
        tick();
        inst_rd_req = 0; rd_rdy = 1;
        tick();
        rd_rdy = 0; ret_valid = 1; ret_last = 0; ret_data = 32'h1;
        tick();
        chk("early_last_no_err_yet", proto_err, 0);
        ret_last = 1; ret_data = 32'h2;
        tick();
        ret_valid = 0; ret_last = 0;
        chk("early_last_err", proto_err, 1);
        chk("early_last_idle", busy, 0);
        tick();
        chk("early_last_sticky", proto_err, 1);

        // reset during RESP beat 2, stray beat afterwards, fresh request
        inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1FC0_0080;
        tick();
        inst_rd_req = 0; rd_rdy = 1;
        tick();
        rd_rdy = 0; ret_valid = 1; ret_data = 32'h11;
        tick();
        ret_data = 32'h22;
        reset = 1;
        #1;
        chk_all_zero("mid_resp_reset");
        tick();
        reset = 0;
        tick();
        chk("stray_beat_err", proto_err, 1);
        chk("stray_beat_idle", busy, 0);
        ret_valid = 0;
        data_rd_req = 1; data_rd_type = 3'b000; data_rd_addr = 32'h0000_0080;
        tick();
        chk("fresh_addr", rd_addr, 32'h0000_0080);
        data_rd_req = 0;
        serve_word(1, "fresh");
        chk("fresh_done", busy, 0);

        // single-beat read whose only beat lacks last
        reset = 1;
        tick();
        reset = 0;
        tick();
        chk("underrun_err_clear", proto_err, 0);
        data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_0300;
        tick();
        data_rd_req = 0; rd_rdy = 1;
        tick();
        rd_rdy = 0; ret_valid = 1; ret_last = 0;
        tick();
        ret_valid = 0;
        chk("underrun_idle", busy, 0);
        chk("underrun_err", proto_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
